spi_cmd_engine: RTL

- Consumes the receive-byte stream that the SPI interface writes into receive memory (rcMemWE/rcMemData) and parses command packets.
- Buffers each packet's payload internally and validates its checksum.
- Writes a response packet into the transmit memory's write port, so the SPI master reads the answer back on its next transaction.
- Sits between spiifc's receive side and the tx memory write port, in parallel with the receive memory.

---
 rtl/spi_cmd_engine_if.sv | 32 +++
 rtl/spi_cmd_engine.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_engine_if.sv
// spi_cmd_engine_if: groups the byte-stream and tx-memory write signals of spi_cmd_engine.
//   rcMemWE   - one-cycle strobe, rcMemData holds a freshly received SPI byte
//   rcMemData - received byte
//   txWrAddr  - tx memory write address
//   txWrData  - tx memory write data
//   txWrWE    - tx memory write enable
// master: the SPI receive side / tx memory. slave: the command engine.
interface spi_cmd_engine_if #(
   parameter int unsigned ADDR_W = 12
);
   logic              rcMemWE;
   logic [7:0]        rcMemData;
   logic [ADDR_W-1:0] txWrAddr;
   logic [7:0]        txWrData;
   logic              txWrWE;

   modport master (
      output rcMemWE,
      output rcMemData,
      input  txWrAddr,
      input  txWrData,
      input  txWrWE
   );

   modport slave (
      input  rcMemWE,
      input  rcMemData,
      output txWrAddr,
      output txWrData,
      output txWrWE
   );
endinterface

// File: rtl/spi_cmd_engine.sv
// spi_cmd_engine: parses command packets (opcode, LEN, payload, chk) from the SPI receive-byte
// stream, validates the checksum and writes a response packet into tx memory.
// Ports:
//   SysClk     - system clock, rising edge
//   Reset      - synchronous active-low reset
//   spi_ss     - raw SPI slave select (active low, asynchronous)
//   bus        - slave side of spi_cmd_engine_if (rx byte strobe in, tx memory write out)
//   cmd_done   - one-cycle pulse after the last response byte is written
//   cmd_opcode - opcode of the last good packet
//   err_flags  - sticky {overrun, short, len, chksum}
//   cmd_count  - good packet count (wraps)
//   debug_out  - {state, cmd_count[4:0]}
module spi_cmd_engine #(
   parameter int unsigned          MAX_LEN = 16,
   parameter int unsigned          ADDR_W  = 12,
   parameter logic [ADDR_W-1:0]    TX_BASE = '0
) (
   input  logic                   SysClk,
   input  logic                   Reset,
   input  logic                   spi_ss,
   spi_cmd_engine_if.slave        bus,
   output logic                   cmd_done,
   output logic [7:0]             cmd_opcode,
   output logic [3:0]             err_flags,
   output logic [7:0]             cmd_count,
   output logic [7:0]             debug_out
);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StLen     = 3'd1,
      StPayload = 3'd2,
      StChk     = 3'd3,
      StResp    = 3'd4,
      StDiscard = 3'd5
   } state_e;

   localparam logic [7:0] MaxLen8 = 8'(MAX_LEN);

   // Error flag bit positions
   localparam int unsigned ErrChk  = 0;
   localparam int unsigned ErrLen  = 1;
   localparam int unsigned ErrShrt = 2;
   localparam int unsigned ErrOvr  = 3;

   state_e      state_q, state_d;
   logic        ss_meta_q, ss_sync_q, ss_prev_q;
   logic [7:0]  opcode_q, opcode_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  sum_q, sum_d;
   logic [7:0]  idx_q, idx_d;
   logic        good_q, good_d;
   logic [7:0]  rchk_q, rchk_d;
   logic [8:0]  ridx_q, ridx_d;
   logic        frame_seen_q, frame_seen_d;
   logic        post_resp_q, post_resp_d;
   logic        cmd_done_q, cmd_done_d;
   logic [7:0]  cmd_opcode_q, cmd_opcode_d;
   logic [3:0]  err_q, err_d;
   logic [7:0]  cmd_count_q, cmd_count_d;
   logic [7:0]  buf_q [MAX_LEN];
   logic        buf_we;

   logic        frame_end;
   logic [7:0]  final_sum;
   logic [8:0]  resp_len;
   logic        resp_last;
   logic [8:0]  rd_idx;
   logic [7:0]  buf_rd;
   logic        tx_we;
   logic [7:0]  tx_data;

   // Rising edge of the synchronized slave select marks the end of a frame.
   assign frame_end = ss_sync_q & ~ss_prev_q;
   assign final_sum = sum_q + bus.rcMemData;
   assign resp_len  = good_q ? ({1'b0, len_q} + 9'd4) : 9'd4;
   assign resp_last = (ridx_q == (resp_len - 9'd1));

   always_comb begin
      state_d      = state_q;
      opcode_d     = opcode_q;
      len_d        = len_q;
      sum_d        = sum_q;
      idx_d        = idx_q;
      good_d       = good_q;
      rchk_d       = rchk_q;
      ridx_d       = ridx_q;
      frame_seen_d = frame_seen_q;
      post_resp_d  = post_resp_q;
      cmd_done_d   = 1'b0;
      cmd_opcode_d = cmd_opcode_q;
      err_d        = err_q;
      cmd_count_d  = cmd_count_q;
      buf_we       = 1'b0;

      // Byte processing first; frame_end is then applied to the resulting state.
      case (state_q)
         StIdle: begin
            if (bus.rcMemWE) begin
               if (post_resp_q) begin
                  // Trailing bytes of a frame that already got its response.
                  state_d = StDiscard;
               end else begin
                  opcode_d = bus.rcMemData;
                  sum_d    = bus.rcMemData;
                  state_d  = StLen;
               end
            end
         end
         StLen: begin
            if (bus.rcMemWE) begin
               if (bus.rcMemData > MaxLen8) begin
                  err_d[ErrLen] = 1'b1;
                  state_d       = StDiscard;
               end else begin
                  len_d   = bus.rcMemData;
                  sum_d   = final_sum;
                  idx_d   = 8'd0;
                  state_d = (bus.rcMemData == 8'd0) ? StChk : StPayload;
               end
            end
         end
         StPayload: begin
            if (bus.rcMemWE) begin
               buf_we = 1'b1;
               sum_d  = final_sum;
               idx_d  = idx_q + 8'd1;
               if ((idx_q + 8'd1) == len_q) begin
                  state_d = StChk;
               end
            end
         end
         StChk: begin
            if (bus.rcMemWE) begin
               ridx_d       = 9'd0;
               frame_seen_d = 1'b0;
               state_d      = StResp;
               if (final_sum == 8'd0) begin
                  good_d = 1'b1;
                  // Packet sums to zero, so rchk = -(A5 - chk).
                  rchk_d = bus.rcMemData - 8'hA5;
               end else begin
                  good_d        = 1'b0;
                  err_d[ErrChk] = 1'b1;
                  rchk_d        = 8'h00 - (8'h5A + opcode_q);
               end
            end
         end
         StResp: begin
            if (bus.rcMemWE) begin
               err_d[ErrOvr] = 1'b1;
            end
            if (resp_last) begin
               state_d     = StIdle;
               cmd_done_d  = 1'b1;
               post_resp_d = ~(frame_seen_q | frame_end);
               if (good_q) begin
                  cmd_opcode_d = opcode_q;
                  cmd_count_d  = cmd_count_q + 8'd1;
               end
            end else begin
               ridx_d = ridx_q + 9'd1;
            end
         end
         StDiscard: begin
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (frame_end) begin
         case (state_d)
            StLen, StPayload, StChk: begin
               err_d[ErrShrt] = 1'b1;
               state_d        = StIdle;
               post_resp_d    = 1'b0;
            end
            StResp: begin
               frame_seen_d = 1'b1;
            end
            default: begin
               state_d     = StIdle;
               post_resp_d = 1'b0;
            end
         endcase
      end
   end

   // Response byte generation
   assign rd_idx = ridx_q - 9'd3;

   always_comb begin
      buf_rd = 8'h00;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
         if (rd_idx == 9'(i)) begin
            buf_rd = buf_q[i];
         end
      end
   end

   assign tx_we = (state_q == StResp);

   always_comb begin
      tx_data = 8'h00;
      if (tx_we) begin
         if (ridx_q == 9'd0) begin
            tx_data = good_q ? 8'hA5 : 8'h5A;
         end else if (ridx_q == 9'd1) begin
            tx_data = opcode_q;
         end else if (ridx_q == 9'd2) begin
            tx_data = good_q ? len_q : 8'h00;
         end else if (resp_last) begin
            tx_data = rchk_q;
         end else begin
            tx_data = buf_rd;
         end
      end
   end

   assign bus.txWrWE   = tx_we;
   assign bus.txWrData = tx_data;
   assign bus.txWrAddr = tx_we ? (TX_BASE + ADDR_W'(ridx_q)) : '0;

   assign cmd_done   = cmd_done_q;
   assign cmd_opcode = cmd_opcode_q;
   assign err_flags  = err_q;
   assign cmd_count  = cmd_count_q;
   assign debug_out  = {state_q, cmd_count_q[4:0]};

   always_ff @(posedge SysClk) begin
      if (!Reset) begin
         state_q      <= StIdle;
         // Idle-high so leaving reset never fakes a frame_end.
         ss_meta_q    <= 1'b1;
         ss_sync_q    <= 1'b1;
         ss_prev_q    <= 1'b1;
         opcode_q     <= 8'h00;
         len_q        <= 8'h00;
         sum_q        <= 8'h00;
         idx_q        <= 8'h00;
         good_q       <= 1'b0;
         rchk_q       <= 8'h00;
         ridx_q       <= 9'd0;
         frame_seen_q <= 1'b0;
         post_resp_q  <= 1'b0;
         cmd_done_q   <= 1'b0;
         cmd_opcode_q <= 8'h00;
         err_q        <= 4'h0;
         cmd_count_q  <= 8'h00;
      end else begin
         state_q      <= state_d;
         ss_meta_q    <= spi_ss;
         ss_sync_q    <= ss_meta_q;
         ss_prev_q    <= ss_sync_q;
         opcode_q     <= opcode_d;
         len_q        <= len_d;
         sum_q        <= sum_d;
         idx_q        <= idx_d;
         good_q       <= good_d;
         rchk_q       <= rchk_d;
         ridx_q       <= ridx_d;
         frame_seen_q <= frame_seen_d;
         post_resp_q  <= post_resp_d;
         cmd_done_q   <= cmd_done_d;
         cmd_opcode_q <= cmd_opcode_d;
         err_q        <= err_d;
         cmd_count_q  <= cmd_count_d;
      end
   end

   // Payload buffer needs no reset; contents are only read after being written.
   always_ff @(posedge SysClk) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
         if (buf_we && (idx_q == 8'(i))) begin
            buf_q[i] <= bus.rcMemData;
         end
      end
   end

endmodule
